// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core.
// Holds datapath widths, the NOP encoding and the pipeline-register payload
// struct. The IF/ID struct is reused by the later ID/EX, EX/MEM and MEM/WB
// registers. No ports.
package mips_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc4;
      logic               valid;
   } if_id_t;

   // Empty pipeline slot: NOP instruction, zero PC+4, not valid.
   localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};

   // Instruction addresses must be word aligned.
   function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's handshake, memory and status signals.
// slave  : fetch_stage side (takes stall/redirect/imem_rdata, drives the rest).
// master : environment side (hazard unit, ID stage, instruction memory).
//   stall, redirect, redirect_target : control from hazard unit / ID stage
//   imem_addr, imem_rdata            : combinational instruction memory port
//   if_id_instr, if_id_pc4, if_id_valid : IF/ID register contents
//   misalign_err                     : sticky misaligned-redirect flag
//   fetch_cnt, stall_cnt, flush_cnt  : saturating performance counters
interface fetch_stage_if #(
   parameter int unsigned CNT_W = 16
) ();
   import mips_pkg::*;

   logic                 stall;
   logic                 redirect;
   logic [ADDR_W-1:0]    redirect_target;
   logic [ADDR_W-1:0]    imem_addr;
   logic [INSTR_W-1:0]   imem_rdata;
   logic [INSTR_W-1:0]   if_id_instr;
   logic [ADDR_W-1:0]    if_id_pc4;
   logic                 if_id_valid;
   logic                 misalign_err;
   logic [CNT_W-1:0]     fetch_cnt;
   logic [CNT_W-1:0]     stall_cnt;
   logic [CNT_W-1:0]     flush_cnt;

   modport slave (
      input  stall, redirect, redirect_target, imem_rdata,
      output imem_addr, if_id_instr, if_id_pc4, if_id_valid,
             misalign_err, fetch_cnt, stall_cnt, flush_cnt
   );

   modport master (
      output stall, redirect, redirect_target, imem_rdata,
      input  imem_addr, if_id_instr, if_id_pc4, if_id_valid,
             misalign_err, fetch_cnt, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset : clock, synchronous active-high reset (loads a bubble)
//   load_en    : capture d this edge
//   flush      : load a bubble this edge; wins over load_en
//   d, q       : next / current IF/ID payload
module if_id_reg
   import mips_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   load_en,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);

   if_id_t ifid_q;
   if_id_t ifid_d;

   always_comb begin
      ifid_d = ifid_q;
      if (flush) begin
         ifid_d = IF_ID_BUBBLE;
      end else if (load_en) begin
         ifid_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_q <= IF_ID_BUBBLE;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign q = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register for the pipelined MIPS core.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : fetch_stage_if.slave -- stall/redirect control, instruction
//           memory port, IF/ID outputs, misalign flag and counters
// Per-edge priority: reset > redirect > stall > normal advance.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.slave  bus
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_plus4;
   logic              misalign_q, misalign_d;
   logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   if_id_t            if_id_next;
   if_id_t            if_id_cur;

   // Wraps modulo 2^32.
   assign pc_plus4 = pc_q + ADDR_W'(4);

   always_comb begin
      pc_d        = pc_q;
      misalign_d  = misalign_q;
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.redirect) begin
         // Low bits are dropped from the PC but still raise the sticky flag.
         pc_d = {bus.redirect_target[ADDR_W-1:2], 2'b00};
         if (is_misaligned(bus.redirect_target)) begin
            misalign_d = 1'b1;
         end
         if (flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end else if (bus.stall) begin
         if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
      end else begin
         pc_d = pc_plus4;
         if (fetch_cnt_q != '1) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         misalign_q  <= 1'b0;
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         misalign_q  <= misalign_d;
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign if_id_next = '{instr: bus.imem_rdata, pc4: pc_plus4, valid: 1'b1};

   // Redirect squashes the wrong-path fetch even when stall is also high.
   if_id_reg u_if_id_reg (
      .clk     (clk),
      .reset   (reset),
      .load_en (~bus.stall),
      .flush   (bus.redirect),
      .d       (if_id_next),
      .q       (if_id_cur)
   );

   assign bus.imem_addr    = pc_q;
   assign bus.if_id_instr  = if_id_cur.instr;
   assign bus.if_id_pc4    = if_id_cur.pc4;
   assign bus.if_id_valid  = if_id_cur.valid;
   assign bus.misalign_err = misalign_q;
   assign bus.fetch_cnt    = fetch_cnt_q;
   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

   logic clk;
   logic reset;
   logic [31:0] mem [256];

   int unsigned n_cmp;
   int unsigned n_err;

   // Behavioural model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_mis;
   int unsigned m_fetch, m_stall, m_flush;

   fetch_stage_if #(.CNT_W(CNT_W)) bus ();

   fetch_stage #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.imem_rdata = mem[bus.imem_addr[9:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge with the given inputs; advances the model by the rules
   // reset > redirect > stall > advance, then waits until just after the edge.
   task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
      reset               = rst;
      bus.stall           = st;
      bus.redirect        = rd;
      bus.redirect_target = tgt;
      @(posedge clk);
      if (rst) begin
         m_pc = RESET_PC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_mis = 1'b0; m_fetch = 0; m_stall = 0; m_flush = 0;
      end else if (rd) begin
         m_pc = tgt & 32'hFFFF_FFFC;
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         if (tgt % 4 != 0) m_mis = 1'b1;
         if (m_flush < CNT_MAX) m_flush++;
      end else if (st) begin
         if (m_stall < CNT_MAX) m_stall++;
      end else begin
         m_instr = mem[(m_pc / 4) % 256];
         m_pc4   = m_pc + 32'd4;
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
         if (m_fetch < CNT_MAX) m_fetch++;
      end
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b1, 32'h0000_0123);
      reset = 1'b0;
      n_cmp++; if (bus.imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_pc got %h exp %h", bus.imem_addr, RESET_PC); end
      n_cmp++; if (bus.if_id_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h exp 0", bus.if_id_instr); end
      n_cmp++; if (bus.if_id_pc4 !== 32'h0) begin n_err++; $display("FAIL reset_pc4 got %h exp 0", bus.if_id_pc4); end
      n_cmp++; if (bus.if_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", bus.if_id_valid); end
      n_cmp++; if (bus.misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_mis got %b exp 0", bus.misalign_err); end
      n_cmp++; if ({bus.fetch_cnt, bus.stall_cnt, bus.flush_cnt} !== '0) begin n_err++; $display("FAIL reset_cnts got %h/%h/%h exp 0/0/0", bus.fetch_cnt, bus.stall_cnt, bus.flush_cnt); end
   endtask

   task automatic test_sequential();
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (bus.if_id_instr !== 32'h2008_0005) begin n_err++; $display("FAIL seq1_instr got %h exp 20080005", bus.if_id_instr); end
      n_cmp++; if (bus.if_id_pc4 !== 32'h4) begin n_err++; $display("FAIL seq1_pc4 got %h exp 4", bus.if_id_pc4); end
      n_cmp++; if (bus.if_id_valid !== 1'b1) begin n_err++; $display("FAIL seq1_valid got %b exp 1", bus.if_id_valid); end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (bus.if_id_instr !== 32'h2009_0003) begin n_err++; $display("FAIL seq2_instr got %h exp 20090003", bus.if_id_instr); end
      n_cmp++; if (bus.if_id_pc4 !== 32'h8) begin n_err++; $display("FAIL seq2_pc4 got %h exp 8", bus.if_id_pc4); end
      n_cmp++; if (bus.imem_addr !== 32'h8) begin n_err++; $display("FAIL seq2_addr got %h exp 8", bus.imem_addr); end
      n_cmp++; if (bus.fetch_cnt !== CNT_W'(2)) begin n_err++; $display("FAIL seq2_fetch_cnt got %0d exp 2", bus.fetch_cnt); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         n_cmp++; if (bus.imem_addr !== 32'h8) begin n_err++; $display("FAIL stall_addr got %h exp 8", bus.imem_addr); end
         n_cmp++; if (bus.if_id_instr !== 32'h2009_0003 || bus.if_id_pc4 !== 32'h8) begin n_err++; $display("FAIL stall_hold got %h/%h exp 20090003/8", bus.if_id_instr, bus.if_id_pc4); end
      end
      n_cmp++; if (bus.stall_cnt !== CNT_W'(3)) begin n_err++; $display("FAIL stall_cnt got %0d exp 3", bus.stall_cnt); end
      n_cmp++; if (bus.fetch_cnt !== CNT_W'(2)) begin n_err++; $display("FAIL stall_fetch_cnt got %0d exp 2", bus.fetch_cnt); end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (bus.if_id_instr !== mem[2] || bus.if_id_pc4 !== 32'hC) begin n_err++; $display("FAIL stall_release got %h/%h exp %h/c", bus.if_id_instr, bus.if_id_pc4, mem[2]); end
   endtask

   task automatic test_redirect();
      step(1'b0, 1'b0, 1'b1, 32'h40);
      n_cmp++; if (bus.imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_addr got %h exp 40", bus.imem_addr); end
      n_cmp++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0) begin n_err++; $display("FAIL redir_bubble got %b/%h exp 0/0", bus.if_id_valid, bus.if_id_instr); end
      n_cmp++; if (bus.flush_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL redir_flush_cnt got %0d exp 1", bus.flush_cnt); end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (bus.if_id_instr !== mem[16] || bus.if_id_pc4 !== 32'h44) begin n_err++; $display("FAIL redir_next got %h/%h exp %h/44", bus.if_id_instr, bus.if_id_pc4, mem[16]); end
   endtask

   task automatic test_stall_redirect();
      step(1'b0, 1'b1, 1'b1, 32'h80);
      n_cmp++; if (bus.imem_addr !== 32'h80) begin n_err++; $display("FAIL sr_addr got %h exp 80", bus.imem_addr); end
      n_cmp++; if (bus.if_id_valid !== 1'b0) begin n_err++; $display("FAIL sr_valid got %b exp 0", bus.if_id_valid); end
      n_cmp++; if (bus.stall_cnt !== CNT_W'(3)) begin n_err++; $display("FAIL sr_stall_cnt got %0d exp 3", bus.stall_cnt); end
      n_cmp++; if (bus.flush_cnt !== CNT_W'(2)) begin n_err++; $display("FAIL sr_flush_cnt got %0d exp 2", bus.flush_cnt); end
   endtask

   task automatic test_misalign();
      step(1'b0, 1'b0, 1'b1, 32'h42);
      n_cmp++; if (bus.imem_addr !== 32'h40) begin n_err++; $display("FAIL mis_addr got %h exp 40", bus.imem_addr); end
      n_cmp++; if (bus.misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_set got %b exp 1", bus.misalign_err); end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0);
         n_cmp++; if (bus.misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_sticky got %b exp 1", bus.misalign_err); end
      end
      step(1'b1, 1'b0, 1'b0, 32'h0);
      reset = 1'b0;
      n_cmp++; if (bus.misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_clear got %b exp 0", bus.misalign_err); end
   endtask

   task automatic test_mid_reset();
      step(1'b0, 1'b0, 1'b1, 32'h40);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (bus.imem_addr !== 32'h44 || bus.if_id_valid !== 1'b1) begin n_err++; $display("FAIL mr_pre got %h/%b exp 44/1", bus.imem_addr, bus.if_id_valid); end
      step(1'b1, 1'b0, 1'b0, 32'h0);
      reset = 1'b0;
      n_cmp++; if (bus.imem_addr !== RESET_PC) begin n_err++; $display("FAIL mr_pc got %h exp %h", bus.imem_addr, RESET_PC); end
      n_cmp++; if (bus.if_id_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid got %b exp 0", bus.if_id_valid); end
      n_cmp++; if ({bus.fetch_cnt, bus.stall_cnt, bus.flush_cnt} !== '0) begin n_err++; $display("FAIL mr_cnts got %h/%h/%h exp 0/0/0", bus.fetch_cnt, bus.stall_cnt, bus.flush_cnt); end
   endtask

   task automatic test_wrap();
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pre got %h exp fffffffc", bus.imem_addr); end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got %h exp 0", bus.imem_addr); end
      n_cmp++; if (bus.if_id_instr !== mem[255] || bus.if_id_pc4 !== 32'h0) begin n_err++; $display("FAIL wrap_ifid got %h/%h exp %h/0", bus.if_id_instr, bus.if_id_pc4, mem[255]); end
   endtask

   // Long random run; also drives the counters into saturation.
   task automatic test_random();
      logic rst, st, rd;
      logic [31:0] tgt;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         rd  = ($urandom_range(0, 6) == 0);
         st  = ($urandom_range(0, 3) == 0);
         tgt = $urandom;
         if ($urandom_range(0, 3) != 0) tgt = tgt & 32'hFFFF_FFFC;
         step(rst, st, rd, tgt);
         n_cmp++; if (bus.imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, bus.imem_addr, m_pc); end
         n_cmp++; if ({bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid} !== {m_instr, m_pc4, m_valid}) begin n_err++; $display("FAIL rnd_ifid cyc %0d got %h/%h/%b exp %h/%h/%b", i, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, m_instr, m_pc4, m_valid); end
         n_cmp++; if (bus.misalign_err !== m_mis) begin n_err++; $display("FAIL rnd_mis cyc %0d got %b exp %b", i, bus.misalign_err, m_mis); end
         n_cmp++; if (bus.fetch_cnt !== CNT_W'(m_fetch) || bus.stall_cnt !== CNT_W'(m_stall) || bus.flush_cnt !== CNT_W'(m_flush)) begin n_err++; $display("FAIL rnd_cnts cyc %0d got %0d/%0d/%0d exp %0d/%0d/%0d", i, bus.fetch_cnt, bus.stall_cnt, bus.flush_cnt, m_fetch, m_stall, m_flush); end
      end
      reset = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h2008_0005;
      mem[1] = 32'h2009_0003;
      reset = 1'b1;
      bus.stall = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_target = 32'h0;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_stall_redirect();
      test_misalign();
      test_mid_reset();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core; the pipelined successor to the single-cycle PC/instruction-memory path.
- Holds the PC, drives the instruction-memory read address, and captures instruction and PC+4 into the IF/ID register for the decode stage.
- Honours stall from the hazard unit and branch/jump redirect from ID.
- Exposes fetch/stall/flush counters for the testbench.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- redirect  in  1  ID stage: branch taken or jump; load redirect_target.
- redirect_target  in  32  new PC, byte address.
- imem_addr  out  32  instruction memory address (= PC), combinational from PC register.
- imem_rdata  in  32  instruction word, combinational read of imem_addr.
- if_id_instr  out  32  registered instruction to decode.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.
- misalign_err  out  1  sticky; set when a redirect target has bits[1:0] != 0.
- fetch_cnt  out  CNT_W  count of instructions accepted into IF/ID.
- stall_cnt  out  CNT_W  count of stalled cycles.
- flush_cnt  out  CNT_W  count of redirects (bubbles inserted).

Behaviour:
- Reset values, applied synchronously at a clk edge with reset=1:
  - PC=RESET_PC.
  - if_id_instr=32'h0 (NOP), if_id_pc4=0, if_id_valid=0.
  - misalign_err=0 and all counters=0.
- Reset overrides stall and redirect. Reset asserted mid-stream discards the IF/ID contents on that edge.
- Per-edge priority when not in reset: redirect > stall > normal advance.
- Normal advance (stall=0, redirect=0):
  - PC <= PC+4.
  - IF/ID <= {imem_rdata, PC+4, valid=1}.
  - fetch_cnt++.
- Stall (stall=1, redirect=0):
  - PC and IF/ID hold all fields.
  - stall_cnt++.
- Redirect (redirect=1, stall ignored):
  - PC <= {redirect_target[31:2], 2'b00}.
  - IF/ID <= bubble (instr=0, pc4=0, valid=0); the wrong-path fetch is squashed.
  - flush_cnt++.
  - If redirect_target[1:0] != 0, set misalign_err; it clears only on reset.
- Redirect and stall asserted together: redirect wins. stall_cnt is not incremented.
- Latency: an instruction at address A appears on if_id_instr one edge after PC==A with no stall or redirect.
- PC arithmetic is modulo 2^32: PC 32'hFFFF_FFFC wraps to 0.
- Counters saturate at all-ones and do not wrap.
- imem_addr is a pure function of the PC register. No combinational path from stall/redirect to imem_addr.
- Consecutive redirects: each one loads its target and inserts a bubble.
- First cycle after reset release: imem_addr=RESET_PC, and if_id_valid stays 0 until the following edge.

Decomposition:
- Shared package mips_pkg holds:
  - constants NOP_INSTR=32'h0, INSTR_W=32, ADDR_W=32;
  - a packed struct if_id_t {instr, pc4, valid}, reused by the later ID/EX, EX/MEM and MEM/WB registers.
- One natural sub-module: if_id_reg.
  - Holds the if_id_t register.
  - Inputs: load_en, flush, d.
  - Flush has priority over load_en.
- PC logic, misalign flag and counters stay in fetch_stage.

Test Plan:
- Sequential fetch: reset for 1 cycle, imem holds 0x20080005 at 0 and 0x20090003 at 4.
  - Edge 1 after release: if_id_instr=0x20080005, if_id_pc4=4, valid=1.
  - Edge 2: 0x20090003, pc4=8, imem_addr=8, fetch_cnt=2.
- Stall: stall=1 for 3 cycles while PC=8.
  - PC stays 8 and IF/ID holds 0x20090003/pc4=8.
  - stall_cnt=3, fetch_cnt unchanged.
  - Release: next edge loads the instruction at address 8.
- Redirect: redirect=1, target=0x40 while PC=0xC.
  - Next edge: PC=0x40, valid=0, instr=0, flush_cnt=1.
  - Following edge: instruction from 0x40, pc4=0x44.
- Simultaneous stall=1 and redirect=1, target=0x80: PC=0x80, bubble inserted, stall_cnt unchanged, flush_cnt incremented.
- Misaligned target 0x42: PC=0x40, misalign_err=1 and stays 1 through 5 normal cycles; reset clears it.
- Reset mid-run at PC=0x44 with valid=1: after one reset edge PC=RESET_PC, valid=0, all counters=0.
- Optional boundary check: PC preloaded by redirect to 0xFFFFFFFC advances to 0.
